// File: rtl/uart_ext_pkg.sv
// rtl/uart_ext_pkg.sv - shared types, constants and helpers for the UART core
package uart_ext_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'd0,
    BITS_6 = 2'd1,
    BITS_7 = 2'd2,
    BITS_8 = 2'd3
  } data_bits_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  localparam int IRQ_TXWM  = 0;
  localparam int IRQ_RXWM  = 1;
  localparam int IRQ_RXTMO = 2;
  localparam int IRQ_ERR   = 3;

  localparam logic [15:0] MIN_DIV = 16'd4;

  // Divisors below MIN_DIV leave no room for a mid-bit sample point
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic logic [7:0] data_mask(input data_bits_e bits);
    case (bits)
      BITS_5:  return 8'h1F;
      BITS_6:  return 8'h3F;
      BITS_7:  return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Index of the final data bit of a frame (4..7)
  function automatic logic [2:0] last_bit(input data_bits_e bits);
    return {1'b0, bits} + 3'd4;
  endfunction

  function automatic logic parity_on(input parity_e par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, registered level and fall-through head
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          wr_ok;
  logic          rd_ok;

  // A push into a full FIFO is refused even when a pop happens in the same cycle
  assign wr_ok   = push_i && !full_o;
  assign rd_ok   = pop_i && !empty_o;
  assign full_o  = (level == LW'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign data_o  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush overrides any push or pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_ok) - LW'(rd_ok);
    end
  end

  // Storage array, no reset needed since reads are gated by level
  always_ff @(posedge clk_i) begin
    if (wr_ok && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down counter with full or half-bit restart
module uart_bit_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        start_i,
  input  logic        half_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt;

  assign tick_o = en_i && !start_i && (cnt == '0);

  // Count div-1..0 and reload; a start realigns the phase to a full or half bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (start_i) begin
      cnt <= half_i ? ((div_i >> 1) - 16'd1) : (div_i - 16'd1);
    end else if (en_i) begin
      cnt <= (cnt == '0) ? (div_i - 16'd1) : (cnt - 16'd1);
    end
  end

endmodule

// File: rtl/uart_ext_core.sv
// rtl/uart_ext_core.sv - UART transceiver with runtime frame format, FIFOs, timeout and IRQ
module uart_ext_core
  import uart_ext_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 16,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int TIMEOUT_W     = 8,
  localparam int LVL_W = $clog2(((TX_FIFO_DEPTH > RX_FIFO_DEPTH) ? TX_FIFO_DEPTH : RX_FIFO_DEPTH) + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_tx_en_i,
  input  logic                 cfg_rx_en_i,
  input  logic [15:0]          cfg_baud_div_i,
  input  logic [1:0]           cfg_data_bits_i,
  input  logic [1:0]           cfg_parity_i,
  input  logic                 cfg_stop2_i,
  input  logic [LVL_W-1:0]     cfg_tx_wm_i,
  input  logic [LVL_W-1:0]     cfg_rx_wm_i,
  input  logic [TIMEOUT_W-1:0] cfg_rx_tmo_i,
  input  logic [3:0]           cfg_irq_en_i,
  input  logic                 tx_flush_i,
  input  logic                 rx_flush_i,
  input  logic                 err_clr_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [7:0]           tx_data_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [7:0]           rx_data_o,
  output logic [LVL_W-1:0]     tx_level_o,
  output logic [LVL_W-1:0]     rx_level_o,
  output logic                 tx_idle_o,
  output logic                 rx_idle_o,
  output logic [2:0]           err_o,
  output logic                 irq_o,
  output logic                 tx_pin_o,
  input  logic                 rx_pin_i
);

  // ---------------- TX path ----------------
  tx_state_e  tx_state;
  logic [7:0] tx_head;
  logic [7:0] tx_masked;
  logic [7:0] tx_shreg;
  logic [2:0] tx_bit;
  logic [2:0] tx_last;
  logic [15:0] tx_div;
  logic [15:0] tx_timer_div;
  logic       tx_par_on;
  logic       tx_par_bit;
  logic       tx_stop2;
  logic       tx_empty;
  logic       tx_full;
  logic       tx_pop;
  logic       tx_tick;
  logic       tx_busy_q;
  logic       tx_pin_q;

  assign tx_masked    = tx_head & data_mask(data_bits_e'(cfg_data_bits_i));
  assign tx_pop       = cfg_tx_en_i && (tx_state == TX_IDLE) && !tx_empty && !tx_flush_i;
  assign tx_timer_div = tx_pop ? eff_div(cfg_baud_div_i) : tx_div;

  sync_fifo #(.DEPTH(TX_FIFO_DEPTH), .W(8), .LW(LVL_W)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (tx_flush_i),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  uart_bit_timer u_tx_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (tx_state != TX_IDLE),
    .start_i (tx_pop),
    .half_i  (1'b0),
    .div_i   (tx_timer_div),
    .tick_o  (tx_tick)
  );

  // TX frame sequencer; the pin register follows the state one cycle later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state   <= TX_IDLE;
      tx_pin_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shreg   <= '0;
      tx_bit     <= '0;
      tx_last    <= 3'd7;
      tx_par_on  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_div     <= MIN_DIV;
    end else if (!cfg_tx_en_i) begin
      tx_state  <= TX_IDLE;
      tx_pin_q  <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      tx_busy_q <= (tx_state != TX_IDLE);
      case (tx_state)
        TX_IDLE: begin
          tx_pin_q <= 1'b1;
          if (tx_pop) begin
            tx_shreg   <= tx_masked;
            tx_last    <= last_bit(data_bits_e'(cfg_data_bits_i));
            tx_par_on  <= parity_on(parity_e'(cfg_parity_i));
            tx_par_bit <= (^tx_masked) ^ (parity_e'(cfg_parity_i) == PAR_ODD);
            tx_stop2   <= cfg_stop2_i;
            tx_div     <= eff_div(cfg_baud_div_i);
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          tx_pin_q <= 1'b0;
          if (tx_tick) begin
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_pin_q <= tx_shreg[0];
          if (tx_tick) begin
            tx_shreg <= tx_shreg >> 1;
            if (tx_bit == tx_last) tx_state <= tx_par_on ? TX_PARITY : TX_STOP1;
            else                   tx_bit   <= tx_bit + 3'd1;
          end
        end
        TX_PARITY: begin
          tx_pin_q <= tx_par_bit;
          if (tx_tick) tx_state <= TX_STOP1;
        end
        TX_STOP1: begin
          tx_pin_q <= 1'b1;
          if (tx_tick) tx_state <= tx_stop2 ? TX_STOP2 : TX_IDLE;
        end
        TX_STOP2: begin
          tx_pin_q <= 1'b1;
          if (tx_tick) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_pin_o   = tx_pin_q;
  assign tx_ready_o = !tx_full;
  assign tx_idle_o  = (tx_state == TX_IDLE) && !tx_busy_q && tx_empty;

  // ---------------- RX path ----------------
  rx_state_e   rx_state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_go;
  logic        rx_tick;
  logic [15:0] rx_div;
  logic [15:0] rx_timer_div;
  logic [7:0]  rx_shreg;
  logic [7:0]  rx_aligned;
  logic [2:0]  rx_bit;
  logic [2:0]  rx_last;
  logic        rx_par_on;
  logic        rx_odd;
  logic        rx_par_smp;
  logic        rx_push_q;
  logic [7:0]  rx_data_q;
  logic        rx_perr_q;
  logic        rx_ferr_q;
  logic        rx_empty;
  logic        rx_full;

  assign rx_go        = cfg_rx_en_i && (rx_state == RX_IDLE) && rx_prev && !rx_s2;
  assign rx_timer_div = (rx_state == RX_IDLE) ? eff_div(cfg_baud_div_i) : rx_div;
  assign rx_aligned   = rx_shreg >> (3'd7 - rx_last);

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_pin_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Free-running while idle so the timeout has a bit-time reference
  uart_bit_timer u_rx_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (cfg_rx_en_i),
    .start_i (rx_go),
    .half_i  (1'b1),
    .div_i   (rx_timer_div),
    .tick_o  (rx_tick)
  );

  // RX frame sequencer sampling at mid-bit; completed byte is pushed one cycle after stop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state   <= RX_IDLE;
      rx_shreg   <= '0;
      rx_bit     <= '0;
      rx_last    <= 3'd7;
      rx_par_on  <= 1'b0;
      rx_odd     <= 1'b0;
      rx_div     <= MIN_DIV;
      rx_par_smp <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      if (!cfg_rx_en_i) begin
        rx_state <= RX_IDLE;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_go) begin
              rx_last   <= last_bit(data_bits_e'(cfg_data_bits_i));
              rx_par_on <= parity_on(parity_e'(cfg_parity_i));
              rx_odd    <= (parity_e'(cfg_parity_i) == PAR_ODD);
              rx_div    <= eff_div(cfg_baud_div_i);
              rx_state  <= RX_START;
            end
          end
          RX_START: begin
            if (rx_tick) begin
              rx_bit   <= '0;
              rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end
          end
          RX_DATA: begin
            if (rx_tick) begin
              rx_shreg <= {rx_s2, rx_shreg[7:1]};
              if (rx_bit == rx_last) rx_state <= rx_par_on ? RX_PARITY : RX_STOP;
              else                   rx_bit   <= rx_bit + 3'd1;
            end
          end
          RX_PARITY: begin
            if (rx_tick) begin
              rx_par_smp <= rx_s2;
              rx_state   <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (rx_tick) begin
              rx_push_q <= 1'b1;
              rx_data_q <= rx_aligned;
              rx_perr_q <= rx_par_on && ((^rx_aligned) ^ rx_odd ^ rx_par_smp);
              rx_ferr_q <= !rx_s2;
              rx_state  <= RX_IDLE;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(.DEPTH(RX_FIFO_DEPTH), .W(8), .LW(LVL_W)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (rx_flush_i),
    .push_i  (rx_push_q),
    .data_i  (rx_data_q),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level_o)
  );

  assign rx_valid_o = !rx_empty;
  assign rx_idle_o  = (rx_state == RX_IDLE);

  // ---------------- status, timeout, interrupt ----------------
  logic [2:0]           err_q;
  logic [2:0]           err_set;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_flag;
  logic                 rx_pop_ok;
  logic [3:0]           irq_src;
  logic                 irq_q;

  assign err_set   = {rx_push_q && rx_full, rx_push_q && rx_ferr_q, rx_push_q && rx_perr_q};
  assign rx_pop_ok = rx_ready_i && !rx_empty;

  // Sticky error bits; a new error in the clear cycle survives
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= (err_q & ~{3{err_clr_i}}) | err_set;
  end

  // Idle bit-time counter for unread RX data; flag holds until the data is consumed or flushed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (rx_flush_i || rx_pop_ok) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if ((rx_state != RX_IDLE) || rx_empty) begin
      tmo_cnt <= '0;
    end else if (rx_tick && (cfg_rx_tmo_i != '0) && !tmo_flag) begin
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      if ((tmo_cnt + TIMEOUT_W'(1)) == cfg_rx_tmo_i) tmo_flag <= 1'b1;
    end
  end

  always_comb begin
    irq_src            = '0;
    irq_src[IRQ_TXWM]  = cfg_tx_en_i && (tx_level_o <= cfg_tx_wm_i);
    irq_src[IRQ_RXWM]  = (cfg_rx_wm_i != '0) && (rx_level_o >= cfg_rx_wm_i);
    irq_src[IRQ_RXTMO] = tmo_flag;
    irq_src[IRQ_ERR]   = |err_q;
  end

  // Interrupt line registered from the enabled sources
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= |(irq_src & cfg_irq_en_i);
  end

  assign err_o = err_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_ext_core.sv
// tb/tb_uart_ext_core.sv - self-checking bench for uart_ext_core
module tb_uart_ext_core;

  localparam int LVL_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 0, rx_en = 0;
  logic [15:0] baud = 16'd16;
  logic [1:0] dbits = 2'd3, par = 2'd0;
  logic stop2 = 0;
  logic [LVL_W-1:0] tx_wm = '0, rx_wm = '0;
  logic [7:0] rx_tmo = '0;
  logic [3:0] irq_en = '0;
  logic tx_flush = 0, rx_flush = 0, err_clr = 0;
  logic tx_valid = 0, rx_ready = 0;
  logic [7:0] tx_data = '0;
  logic tx_ready, rx_valid, tx_idle, rx_idle, irq, tx_pin;
  logic [7:0] rx_data;
  logic [LVL_W-1:0] tx_level, rx_level;
  logic [2:0] err;
  logic loop = 0, drv = 1;
  logic rx_line;

  assign rx_line = loop ? tx_pin : drv;

  uart_ext_core dut (
    .clk_i(clk), .rst_i(rst), .cfg_tx_en_i(tx_en), .cfg_rx_en_i(rx_en),
    .cfg_baud_div_i(baud), .cfg_data_bits_i(dbits), .cfg_parity_i(par),
    .cfg_stop2_i(stop2), .cfg_tx_wm_i(tx_wm), .cfg_rx_wm_i(rx_wm),
    .cfg_rx_tmo_i(rx_tmo), .cfg_irq_en_i(irq_en), .tx_flush_i(tx_flush),
    .rx_flush_i(rx_flush), .err_clr_i(err_clr), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .tx_data_i(tx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .rx_data_o(rx_data), .tx_level_o(tx_level),
    .rx_level_o(rx_level), .tx_idle_o(tx_idle), .rx_idle_o(rx_idle),
    .err_o(err), .irq_o(irq), .tx_pin_o(tx_pin), .rx_pin_i(rx_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int data; int bits; int par; int stop2; int div;
    int exp_rx; int exp_err;
  } vec_t;
  vec_t vecs[10];
  int exp_q[$];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: effective divisor, data mask, and the line bits of a frame (LSB = start bit)
  function automatic int m_div(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  function automatic int m_mask(input int bits);
    return (1 << (bits + 5)) - 1;
  endfunction

  function automatic int m_frame(input int data, input int bits, input int p, input int s2, output int len);
    int f, pos, ones;
    f = 0; pos = 1; ones = 0;
    for (int i = 0; i < bits + 5; i++) begin
      f |= ((data >> i) & 1) << pos;
      ones += (data >> i) & 1;
      pos++;
    end
    if (p == 1 || p == 2) begin
      f |= (((ones % 2) ^ (p == 2 ? 1 : 0)) & 1) << pos;
      pos++;
    end
    f |= 1 << pos; pos++;
    if (s2 != 0) begin f |= 1 << pos; pos++; end
    len = pos;
    return f;
  endfunction

  task automatic set_cfg(input int div, input int bits, input int p, input int s2);
    baud = 16'(div); dbits = 2'(bits); par = 2'(p); stop2 = s2[0];
  endtask

  task automatic push_tx(input int data);
    tx_data = 8'(data); tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic pop_rx();
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  task automatic wait_pin_low(output bit ok);
    int w;
    w = 0;
    while (tx_pin !== 1'b0 && w < 400) begin @(negedge clk); w++; end
    ok = (w < 400);
  endtask

  // Sample the TX line at each mid-bit, then time the frame until tx_idle_o returns
  task automatic capture_tx(input int div, input int len, output int bits, output int dur);
    bit ok;
    int t0, w;
    bits = 0; dur = -1;
    wait_pin_low(ok);
    chk("tx_start_seen", ok, 1);
    if (!ok) return;
    t0 = cyc;
    step(div / 2);
    bits |= int'(tx_pin);
    for (int k = 1; k < len; k++) begin
      step(div);
      bits |= int'(tx_pin) << k;
    end
    w = 0;
    while (!tx_idle && w < 4 * div) begin @(negedge clk); w++; end
    dur = cyc - t0;
  endtask

  task automatic wait_rx(input int lim);
    int w;
    w = 0;
    while (!rx_valid && w < lim) begin @(negedge clk); w++; end
    chk("rx_valid_seen", rx_valid, 1);
  endtask

  task automatic send_rx(input int frame, input int len, input int div);
    for (int k = 0; k < len; k++) begin
      drv = frame[k];
      step(div);
    end
    drv = 1;
  endtask

  initial begin
    int fr, len, got, dur, d, f2;
    bit ok;

    // ---- reset state ----
    step(3);
    chk("rst_tx_pin", tx_pin, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_err", err, 0);
    chk("rst_irq", irq, 0);
    chk("rst_idles", {tx_idle, rx_idle}, 2'b11);
    rst = 0;
    step(2);

    // ---- table-driven loopback frames ----
    vecs[0] = '{8'hA5, 3, 0, 0, 16, 0, 0};
    vecs[1] = '{8'h55, 2, 1, 1, 8, 0, 0};
    vecs[2] = '{8'h3C, 3, 2, 0, 2, 0, 0};
    vecs[3] = '{8'hF3, 0, 2, 1, 0, 0, 0};
    for (int i = 4; i < 10; i++)
      vecs[i] = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), int'($urandom_range(3, 12)), 0, 0};
    for (int i = 0; i < 10; i++) vecs[i].exp_rx = vecs[i].data & m_mask(vecs[i].bits);

    loop = 1; tx_en = 1; rx_en = 1;
    for (int i = 0; i < 10; i++) begin
      d = m_div(vecs[i].div);
      fr = m_frame(vecs[i].data, vecs[i].bits, vecs[i].par, vecs[i].stop2, len);
      set_cfg(vecs[i].div, vecs[i].bits, vecs[i].par, vecs[i].stop2);
      push_tx(vecs[i].data);
      capture_tx(d, len, got, dur);
      chk($sformatf("v%0d_tx_frame", i), got, fr);
      chk($sformatf("v%0d_tx_cycles", i), dur, len * d);
      wait_rx(4 * d);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      pop_rx();
      step(2);
    end
    chk("loop_rx_level", rx_level, 0);
    loop = 0; drv = 1;
    step(4);

    // ---- injected parity and stop errors, 8O1 ----
    set_cfg(8, 3, 2, 0);
    fr = m_frame(8'h3C, 3, 2, 0, len);
    send_rx(fr ^ (1 << 9), len, 8);
    wait_rx(40);
    chk("perr_data", rx_data, 8'h3C);
    chk("perr_err", err, 3'b001);
    err_clr = 1; step(1); err_clr = 0; step(1);
    chk("perr_clr", err, 0);
    pop_rx();
    send_rx(fr ^ (1 << 10), len, 8);
    wait_rx(40);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_err", err, 3'b010);
    pop_rx();
    err_clr = 1; step(1); err_clr = 0; step(2);

    // ---- RX overrun on full FIFO ----
    set_cfg(4, 3, 0, 0);
    for (int i = 0; i < 17; i++) begin
      d = int'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back(d);
      fr = m_frame(d, 3, 0, 0, len);
      send_rx(fr, len, 4);
      if (i == 15) begin
        step(8);
        chk("ovr_level16", rx_level, 16);
        chk("ovr_err_before", err, 0);
      end
    end
    step(8);
    chk("ovr_level_kept", rx_level, 16);
    chk("ovr_err", err, 3'b100);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_pop%0d", i), rx_data, exp_q[i]);
      pop_rx();
    end
    chk("ovr_empty", rx_valid, 0);
    err_clr = 1; step(1); err_clr = 0; step(1);

    // ---- RX idle timeout interrupt ----
    set_cfg(8, 3, 0, 0);
    rx_tmo = 8'd4; irq_en = 4'b0100;
    fr = m_frame(8'h81, 3, 0, 0, len);
    send_rx(fr, len, 8);
    wait_rx(40);
    chk("tmo_data", rx_data, 8'h81);
    step(16);
    chk("tmo_irq_early", irq, 0);
    step(24);
    chk("tmo_irq", irq, 1);
    pop_rx();
    step(2);
    chk("tmo_irq_cleared", irq, 0);
    irq_en = 0; rx_tmo = 0;

    // ---- RX start glitch ----
    set_cfg(16, 3, 0, 0);
    drv = 0; step(2); drv = 1;
    step(40);
    chk("glitch_level", rx_level, 0);
    chk("glitch_idle", rx_idle, 1);

    // ---- TX FIFO full boundary, flush, TX watermark ----
    tx_en = 0;
    for (int i = 0; i < 17; i++) push_tx(i);
    chk("txf_level", tx_level, 16);
    chk("txf_ready", tx_ready, 0);
    tx_flush = 1; step(1); tx_flush = 0;
    chk("txf_flush", tx_level, 0);
    tx_wm = 5'd2; irq_en = 4'b0001; tx_en = 1;
    step(2);
    chk("txwm_irq", irq, 1);
    irq_en = 0;

    // ---- TX disable mid-frame keeps FIFO ----
    set_cfg(8, 3, 0, 0);
    push_tx(8'h00);
    push_tx(8'h00);
    wait_pin_low(ok);
    chk("abort_start_seen", ok, 1);
    step(5);
    tx_en = 0;
    step(1);
    chk("abort_pin", tx_pin, 1);
    chk("abort_level", tx_level, 1);
    tx_flush = 1; step(1); tx_flush = 0;

    // ---- reset mid TX frame ----
    tx_en = 1;
    set_cfg(16, 3, 0, 0);
    push_tx(8'h00);
    push_tx(8'h00);
    wait_pin_low(ok);
    step(20);
    f2 = int'(tx_pin);
    chk("midframe_pin_low", f2, 0);
    rst = 1;
    #1;
    chk("rst_mid_pin", tx_pin, 1);
    chk("rst_mid_tx_level", tx_level, 0);
    chk("rst_mid_ready", tx_ready, 1);
    step(1);
    rst = 0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
